// File: rtl/vigna_pkg.sv
// Shared definitions for the vigna core-to-memory bus arbiter:
// FSM state encoding, port identifiers, default timeout and the
// wait-counter sizing rule.
package vigna_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Identifies which core port owns (or last owned) the memory port.
    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    // Memory-wait cycles before an access is aborted; 0 disables the abort.
    localparam int DEFAULT_TIMEOUT = 255;

    // The wait counter is never narrower than this.
    localparam int MIN_CNT_W = 8;

    // Wait counter width: wide enough to hold TIMEOUT, and at least 8 bits.
    function automatic int wait_cnt_width(input int timeout);
        int bits;
        bits = (timeout > 0) ? $clog2(timeout + 1) : 1;
        return (bits > MIN_CNT_W) ? bits : MIN_CNT_W;
    endfunction

endpackage

// File: rtl/vigna_bus_arb.sv
// Two-to-one bus arbiter joining the vigna core's instruction and data
// ports onto a single memory port.
//
// Handshake: a core port holds x_valid with stable addr/wdata/wstrb until
// it sees x_ready high for one cycle; x_rdata is valid from that cycle on.
// The memory port holds m_valid with stable addr/wdata/wstrb until a cycle
// in which m_ready is high; m_rdata is taken in that same cycle.
//
// One access is in flight at a time. A lone requester is granted directly;
// a tie goes to the port that was not served last. An access that waits
// TIMEOUT cycles without m_ready is aborted: the requester gets its ready
// pulse with rdata of zero, and bus_err pulses alongside it.
module vigna_bus_arb
    import vigna_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        resetn,

    // Core instruction port
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,

    // Core data port; wstrb of zero is a read
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    output logic [31:0] d_rdata,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,

    // Memory port
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    input  logic [31:0] m_rdata,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,

    // One-cycle pulse accompanying the ready of an aborted access
    output logic        bus_err,

    // Current FSM state, for observation only
    output state_t      fsm_state
);

    localparam int               CNT_W       = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_ON  = (TIMEOUT != 0);

    port_t            grant;       // port owning the access in flight
    port_t            last_port;   // port that completed most recently
    logic [CNT_W-1:0] wait_cnt;    // BUSY cycles spent without m_ready

    port_t            pick;
    logic [CNT_W-1:0] wait_inc;
    logic             timeout_hit;

    // Instruction stores are not supported, so i_wstrb is deliberately dropped.
    logic             unused_i_wstrb;
    assign unused_i_wstrb = ^i_wstrb;

    // Arbitration choice: a lone requester wins; a tie goes to the port not served last.
    always_comb begin
        pick = PORT_INSTR;
        if (d_valid && (!i_valid || (last_port == PORT_INSTR))) begin
            pick = PORT_DATA;
        end
    end

    // The abort fires on the cycle whose increment would bring the counter to TIMEOUT.
    assign wait_inc    = wait_cnt + CNT_W'(1);
    assign timeout_hit = TIMEOUT_ON && (wait_inc == TIMEOUT_VAL);

    // Arbiter FSM: grant in IDLE, wait for memory in BUSY, pulse ready in RESP.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fsm_state <= ST_IDLE;
            grant     <= PORT_INSTR;
            last_port <= PORT_DATA;
            wait_cnt  <= '0;
            m_valid   <= 1'b0;
            m_addr    <= 32'h0;
            m_wdata   <= 32'h0;
            m_wstrb   <= 4'h0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= 32'h0;
            d_rdata   <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            // Ready and error are single-cycle pulses unless re-armed below.
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            bus_err <= 1'b0;

            case (fsm_state)
                ST_IDLE: begin
                    if (i_valid || d_valid) begin
                        grant    <= pick;
                        wait_cnt <= '0;
                        m_valid  <= 1'b1;
                        if (pick == PORT_DATA) begin
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_wstrb <= d_wstrb;
                        end else begin
                            m_addr  <= i_addr;
                            m_wdata <= i_wdata;
                            m_wstrb <= 4'h0;
                        end
                        fsm_state <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (m_ready) begin
                        // A memory response always beats a timeout landing in the same cycle.
                        m_valid <= 1'b0;
                        if (grant == PORT_DATA) begin
                            d_rdata <= m_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            i_rdata <= m_rdata;
                            i_ready <= 1'b1;
                        end
                        fsm_state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (timeout_hit) begin
                            m_valid <= 1'b0;
                            bus_err <= 1'b1;
                            if (grant == PORT_DATA) begin
                                d_rdata <= 32'h0;
                                d_ready <= 1'b1;
                            end else begin
                                i_rdata <= 32'h0;
                                i_ready <= 1'b1;
                            end
                            fsm_state <= ST_RESP;
                        end
                    end
                end

                ST_RESP: begin
                    // Requests seen here wait for IDLE, so a requester that
                    // drops valid after its ready pulse is not served twice.
                    last_port <= grant;
                    fsm_state <= ST_IDLE;
                end

                default: begin
                    fsm_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vigna_bus_arb.sv
// Directed and randomized bench for vigna_bus_arb, checked against a
// transaction-level reference model of the arbitration, latency and
// timeout rules.
module tb_vigna_bus_arb;
    import vigna_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_valid, i_ready;
    logic [31:0] i_addr, i_rdata, i_wdata;
    logic [3:0]  i_wstrb;
    logic        d_valid, d_ready;
    logic [31:0] d_addr, d_rdata, d_wdata;
    logic [3:0]  d_wstrb;
    logic        m_valid, m_ready;
    logic [31:0] m_addr, m_rdata, m_wdata;
    logic [3:0]  m_wstrb;
    logic        bus_err;
    state_t      fsm_state;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          last_data;          // 1: data port was served most recently
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_q[$];           // expected m_addr of each granted access

    vigna_bus_arb #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_wdata   (i_wdata),
        .i_wstrb   (i_wstrb),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_addr    (d_addr),
        .d_rdata   (d_rdata),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_rdata   (m_rdata),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .bus_err   (bus_err),
        .fsm_state (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_data   = 1'b1;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_i_ready"}, i_ready, 0);
        check({tag, "_d_ready"}, d_ready, 0);
        check({tag, "_bus_err"}, bus_err, 0);
        check({tag, "_m_addr"},  m_addr, 0);
        check({tag, "_m_wdata"}, m_wdata, 0);
        check({tag, "_m_wstrb"}, m_wstrb, 0);
        check({tag, "_i_rdata"}, i_rdata, 0);
        check({tag, "_d_rdata"}, d_rdata, 0);
        check({tag, "_state"},   fsm_state, ST_IDLE);
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        i_valid = 1'b0;
        d_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic post_i(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        i_valid = 1'b1; i_addr = a; i_wdata = w; i_wstrb = s;
    endtask

    task automatic post_d(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        d_valid = 1'b1; d_addr = a; d_wdata = w; d_wstrb = s;
    endtask

    // Serve one access. Called at a negedge in IDLE with at least one valid
    // raised. lat = m_valid cycle in which memory answers; lat > TO means
    // memory never answers in time and the access must abort after TO cycles.
    task automatic serve(input int lat, input logic [31:0] rd);
        bit          g;
        bit          tmo;
        logic [31:0] ew;
        logic [3:0]  es;
        int          c;
        if (i_valid && d_valid) g = !last_data;
        else                    g = d_valid;
        exp_q.push_back(g ? d_addr : i_addr);
        ew  = g ? d_wdata : i_wdata;
        es  = g ? d_wstrb : 4'h0;
        tmo = (lat > TO);

        @(negedge clk);
        check("grant_m_valid", m_valid, 1);
        check("grant_m_addr",  m_addr, exp_q[0]);
        check("grant_m_wdata", m_wdata, ew);
        check("grant_m_wstrb", m_wstrb, es);
        check("grant_i_ready", i_ready, 0);
        check("grant_d_ready", d_ready, 0);

        c = 1;
        forever begin
            if (!tmo && c == lat) begin
                m_ready = 1'b1; m_rdata = rd;
            end else begin
                m_ready = 1'b0; m_rdata = $urandom;
            end
            @(negedge clk);
            if ((!tmo && c == lat) || (tmo && c == TO)) break;
            c++;
            check("busy_m_valid", m_valid, 1);
            check("busy_m_addr",  m_addr, exp_q[0]);
            check("busy_m_wdata", m_wdata, ew);
            check("busy_m_wstrb", m_wstrb, es);
            check("busy_ready",   {i_ready, d_ready}, 0);
            check("busy_bus_err", bus_err, 0);
        end
        void'(exp_q.pop_front());

        // Response cycle
        m_ready = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
        if (g) exp_d_rdata = tmo ? 32'h0 : rd;
        else   exp_i_rdata = tmo ? 32'h0 : rd;
        check("resp_m_valid", m_valid, 0);
        check("resp_i_ready", i_ready, !g);
        check("resp_d_ready", d_ready, g);
        check("resp_bus_err", bus_err, tmo);
        check("resp_i_rdata", i_rdata, exp_i_rdata);
        check("resp_d_rdata", d_rdata, exp_d_rdata);
        last_data = g;
        if (g) d_valid = 1'b0;
        else   i_valid = 1'b0;

        @(negedge clk);
        m_ready = 1'b0;
        check("after_ready",   {i_ready, d_ready}, 0);
        check("after_bus_err", bus_err, 0);
        check("after_m_valid", m_valid, 0);
        check("after_state",   fsm_state, ST_IDLE);
    endtask

    initial begin
        int k;
        int guard;
        i_valid = 0; i_addr = 0; i_wdata = 0; i_wstrb = 0;
        d_valid = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        m_ready = 0; m_rdata = 0;
        model_reset();

        do_reset();

        // Instruction read alone; i_wstrb must not reach memory
        post_i(32'h100, 32'h1234_5678, 4'hF);
        serve(2, 32'h0000_0013);
        check("ifetch_i_rdata", i_rdata, 32'h13);

        // Store through the data port
        post_d(32'h2000, 32'hDEAD_BEEF, 4'hF);
        serve(1, 32'hA5A5_0001);

        // Data read that times out
        post_d(32'h2004, 32'h0, 4'h0);
        serve(TO + 5, 32'h0);
        check("timeout_d_rdata", d_rdata, 32'h0);

        // Reset while BUSY abandons the access
        post_i(32'h200, 32'h0, 4'h0);
        @(negedge clk);
        check("midrst_m_valid", m_valid, 1);
        @(negedge clk);
        resetn  = 1'b0;
        i_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        resetn  = 1'b1;
        m_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_no_ready", {i_ready, d_ready, bus_err}, 0);
        post_i(32'h204, 32'h0, 4'h0);
        serve(3, 32'h0BAD_F00D);

        // Ties from reset: instruction first, then a repeat tie goes to data
        do_reset();
        post_i(32'h300, 32'h0, 4'h0);
        post_d(32'h4000, 32'h0, 4'h0);
        serve(1, 32'h1111_1111);
        check("tie1_i_rdata", i_rdata, 32'h1111_1111);
        post_i(32'h304, 32'h0, 4'h0);
        serve(2, 32'h2222_2222);
        check("tie2_d_rdata", d_rdata, 32'h2222_2222);
        serve(4, 32'h3333_3333);
        check("tie3_i_rdata", i_rdata, 32'h3333_3333);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 2);
            if (k != 1) post_i({$urandom_range(0, 32'h3FFF), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
            if (k != 0) post_d($urandom, $urandom, 4'($urandom_range(0, 15)));
            guard = 0;
            while ((i_valid || d_valid) && guard < 8) begin
                serve($urandom_range(1, TO + 2), $urandom);
                guard++;
                if (!i_valid && d_valid && $urandom_range(0, 2) == 0)
                    post_i({$urandom_range(0, 32'h3FFF), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
                else if (!d_valid && i_valid && $urandom_range(0, 2) == 0)
                    post_d($urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            repeat ($urandom_range(0, 2)) begin
                m_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("gap_m_valid", m_valid, 0);
                check("gap_ready", {i_ready, d_ready, bus_err}, 0);
            end
            m_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vigna_bus_arb.md
VIGNA_BUS_ARB -- requirements
Module: vigna_bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning memory-wait cycles before an access is aborted; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have ports i_valid in 1, i_ready out 1, i_addr in 32, i_rdata out 32, i_wdata in 32, i_wstrb in 4: the core instruction port.
REQ-005 SHALL have ports d_valid in 1, d_ready out 1, d_addr in 32, d_rdata out 32, d_wdata in 32, d_wstrb in 4: the core data port; wstrb 0 means read.
REQ-006 SHALL have ports m_valid out 1, m_ready in 1, m_addr out 32, m_rdata in 32, m_wdata out 32, m_wstrb out 4: the single memory port.
REQ-007 SHALL have port bus_err, output, 1, a one-cycle pulse on a timed-out access.

Function
REQ-008 SHALL implement states IDLE, BUSY and RESP; all outputs are registered.
REQ-009 In IDLE with exactly one of i_valid or d_valid high, SHALL grant that port and move to BUSY.
REQ-010 In IDLE with both valid, SHALL grant the port not served last; the last-served flag resets to "data", so the first tie goes to instruction.
REQ-011 On grant, SHALL latch the granted port's addr, wdata and wstrb into m_addr, m_wdata and m_wstrb.
REQ-012 On grant, SHALL assert m_valid in the next cycle; an instruction grant forces m_wstrb=0 regardless of i_wstrb.
REQ-013 In BUSY, SHALL hold m_valid, m_addr, m_wdata and m_wstrb stable until a cycle with m_ready=1.
REQ-014 On m_ready=1 in BUSY, SHALL drop m_valid, capture m_rdata into the granted port's rdata register and move to RESP.
REQ-015 In RESP, SHALL hold the granted port's ready high for exactly one cycle, then return to IDLE; the last-served flag updates here.
REQ-016 Latency: request seen in cycle 0 -> m_valid in cycle 1 -> m_ready in cycle k -> x_ready in cycle k+1; minimum 3 cycles request-to-ready.
REQ-017 i_rdata and d_rdata SHALL each hold their last captured value until that port's next response.
REQ-018 The non-granted port SHALL keep ready=0 and its valid stays pending; it is served in the next IDLE.
REQ-019 A valid observed in RESP SHALL NOT be granted until IDLE, so a requester dropping valid after its ready pulse is never re-served.
REQ-020 Wait counter: 8 bits wide or TIMEOUT width, whichever is larger; cleared on grant and incremented each BUSY cycle with m_ready=0.
REQ-021 When TIMEOUT!=0 and the wait counter reaches TIMEOUT, SHALL drop m_valid, load rdata=32'h0 and pulse bus_err together with the RESP ready pulse.
REQ-022 m_ready arriving in the same cycle the timeout is reached SHALL win, giving a normal completion with no bus_err.
REQ-023 m_ready while not in BUSY SHALL be ignored.

Reset
REQ-024 On resetn=0 at a clock edge, SHALL clear m_valid, i_ready, d_ready, bus_err, m_addr, m_wdata, m_wstrb, i_rdata, d_rdata and the wait counter to 0, set state to IDLE and set the last-served flag to "data".
REQ-025 Reset mid-transaction SHALL abandon the access; no ready pulse and no bus_err for it.

Structure
REQ-026 State encodings and the default TIMEOUT SHALL live in shared package vigna_pkg.
REQ-027 SHALL be a single module with no sub-modules; a round-robin unit for two requesters does not justify one.

Verification
REQ-028 Instruction read alone: i_valid, i_addr=0x100, memory ready after 2 cycles with rdata=0x00000013 -> m_addr=0x100, m_wstrb=0, i_ready one cycle, i_rdata=0x13.
REQ-029 Store: d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF -> memory sees those exact values; d_ready one cycle; i_ready stays 0.
REQ-030 Simultaneous i_valid and d_valid from reset -> instruction served first, data second; a repeat tie is served data first.
REQ-031 TIMEOUT=4 with m_ready held 0 -> m_valid drops after 4 wait cycles; d_ready and bus_err pulse together; d_rdata=0.
REQ-032 resetn=0 while in BUSY -> next cycle all outputs are 0; a new i_valid afterwards completes normally.
